// File: rtl/md_unit.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiply and restoring
// divide, one bit per cycle, followed by a single sign-fix cycle.
module md_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t               state_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     opb_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic [CW-1:0]        cnt_q;
  logic                 is_div_q;
  logic                 neg_res_q;
  logic                 neg_rem_q;
  logic                 div0_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 signed_op_d;
  logic                 a_neg_d;
  logic                 b_neg_d;
  logic [WIDTH-1:0]     a_abs_d;
  logic [WIDTH-1:0]     b_abs_d;
  logic [WIDTH:0]       mul_sum_d;
  logic [2*WIDTH-1:0]   mul_acc_d;
  logic [WIDTH:0]       rem_sh_d;
  logic [WIDTH:0]       rem_sub_d;
  logic [2*WIDTH-1:0]   div_acc_d;
  logic [2*WIDTH-1:0]   prod_d;
  logic [WIDTH-1:0]     quot_d;
  logic [WIDTH-1:0]     rem_d;

  // Operand conditioning, one iteration step of each algorithm, and final sign fix
  always_comb begin
    signed_op_d = (op == 3'd0) || (op == 3'd2);
    a_neg_d     = signed_op_d & a[WIDTH-1];
    b_neg_d     = signed_op_d & b[WIDTH-1];
    a_abs_d     = a_neg_d ? ({WIDTH{1'b0}} - a) : a;
    b_abs_d     = b_neg_d ? ({WIDTH{1'b0}} - b) : b;

    // Multiplier lives in the low half of the accumulator; its LSB gates the add
    if (acc_q[0]) begin
      mul_sum_d = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
    end else begin
      mul_sum_d = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    end
    mul_acc_d = {mul_sum_d, acc_q[WIDTH-1:1]};

    // Remainder in the high half, quotient shifts in from the low half
    rem_sh_d  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_sub_d = rem_sh_d - {1'b0, opb_q};
    if (rem_sh_d >= {1'b0, opb_q}) begin
      div_acc_d = {rem_sub_d[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_acc_d = {rem_sh_d[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end

    prod_d = neg_res_q ? ({(2*WIDTH){1'b0}} - acc_q) : acc_q;
    if (div0_q) begin
      quot_d = {WIDTH{1'b1}};
    end else if (neg_res_q) begin
      quot_d = {WIDTH{1'b0}} - acc_q[WIDTH-1:0];
    end else begin
      quot_d = acc_q[WIDTH-1:0];
    end
    rem_d = neg_rem_q ? ({WIDTH{1'b0}} - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
  end

  // Control FSM with registered busy/done and HI/LO ownership
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= {(2*WIDTH){1'b0}};
      opb_q     <= {WIDTH{1'b0}};
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
      cnt_q     <= {CW{1'b0}};
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            case (op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                acc_q     <= {{WIDTH{1'b0}}, (op[1] ? a_abs_d : b_abs_d)};
                opb_q     <= op[1] ? b_abs_d : a_abs_d;
                is_div_q  <= op[1];
                neg_res_q <= a_neg_d ^ b_neg_d;
                neg_rem_q <= a_neg_d;
                div0_q    <= op[1] && (b == {WIDTH{1'b0}});
                cnt_q     <= {CW{1'b0}};
                busy_q    <= 1'b1;
                state_q   <= op[1] ? DIV : MUL;
              end
              3'd4:    hi_q <= a;
              3'd5:    lo_q <= a;
              default: ;
            endcase
          end
        end
        MUL, DIV: begin
          acc_q <= (state_q == DIV) ? div_acc_d : mul_acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH-1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          if (is_div_q) begin
            lo_q <= quot_d;
            hi_q <= rem_d;
          end else begin
            hi_q <= prod_d[2*WIDTH-1:WIDTH];
            lo_q <= prod_d[WIDTH-1:0];
          end
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed corner cases plus random operations
// checked against a plain-arithmetic reference model of HI/LO.
module tb_md_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  md_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: what HI/LO should hold after the operation, from plain arithmetic
  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      p;
    longint      sx;
    longint      sy;
    longint      q;
    longint      r;
    logic [63:0] u;
    case (o)
      3'd0: begin
        p = longint'($signed(x)) * longint'($signed(y));
        exp_hi = p[63:32];
        exp_lo = p[31:0];
      end
      3'd1: begin
        u = {32'd0, x} * {32'd0, y};
        exp_hi = u[63:32];
        exp_lo = u[31:0];
      end
      3'd2: begin
        if (y == 32'd0) begin
          exp_lo = 32'hFFFF_FFFF;
          exp_hi = x;
        end else begin
          sx = longint'($signed(x));
          sy = longint'($signed(y));
          q = sx / sy;
          r = sx % sy;
          exp_lo = q[31:0];
          exp_hi = r[31:0];
        end
      end
      3'd3: begin
        if (y == 32'd0) begin
          exp_lo = 32'hFFFF_FFFF;
          exp_hi = x;
        end else begin
          exp_lo = x / y;
          exp_hi = x % y;
        end
      end
      3'd4: exp_hi = x;
      3'd5: exp_lo = x;
      default: ;
    endcase
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    tick;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  // Issue a mult/div, optionally poke a mult start while busy, and check the
  // 33-cycle busy window, HI/LO hold, done pulse and result. Returns in the done cycle.
  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x,
                     input logic [31:0] y, input int poke);
    logic [31:0] oh;
    logic [31:0] ol;
    int          n;
    logic        held;
    oh = exp_hi;
    ol = exp_lo;
    model(o, x, y);
    issue(o, x, y);
    check({tag, " busy"}, {31'd0, busy}, 32'd1);
    check({tag, " done_drop"}, {31'd0, done}, 32'd0);
    n = 1;
    held = 1'b1;
    while (busy === 1'b1 && n < 60) begin
      if (hi !== oh || lo !== ol || done !== 1'b0) held = 1'b0;
      if (n == poke) begin
        start = 1'b1;
        op = 3'd0;
        a = 32'd3;
        b = 32'd5;
      end else begin
        start = 1'b0;
      end
      tick;
      if (busy === 1'b1) n++;
    end
    start = 1'b0;
    check({tag, " latency"}, 32'(n), 32'd33);
    check({tag, " hold"}, {31'd0, held}, 32'd1);
    check({tag, " done"}, {31'd0, done}, 32'd1);
    check({tag, " hi"}, hi, exp_hi);
    check({tag, " lo"}, lo, exp_lo);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    rst = 1'b1;
    start = 1'b0;
    op = 3'd0;
    a = 32'd0;
    b = 32'd0;
    tick;
    tick;
    rst = 1'b0;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst hi", hi, 32'd0);
    check("rst lo", lo, 32'd0);

    run("mult", 3'd0, 32'hFFFF_FFFF, 32'd2, 0);
    tick;
    check("mult done_pulse", {31'd0, done}, 32'd0);
    run("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 0);
    tick;
    run("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 0);
    tick;
    run("divu", 3'd3, 32'd100, 32'd7, 0);
    tick;
    run("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    tick;
    run("divu_by0", 3'd3, 32'h0000_1234, 32'd0, 0);
    tick;
    run("div_by0_neg", 3'd2, 32'hFFFF_FF00, 32'd0, 0);
    tick;

    // mthi then mtlo on consecutive edges, plus a reserved op
    issue(3'd4, 32'hDEAD_BEEF, 32'd0);
    model(3'd4, 32'hDEAD_BEEF, 32'd0);
    check("mthi hi", hi, exp_hi);
    check("mthi lo", lo, exp_lo);
    check("mthi busy", {31'd0, busy}, 32'd0);
    issue(3'd5, 32'h1234_5678, 32'd0);
    model(3'd5, 32'h1234_5678, 32'd0);
    check("mtlo hi", hi, exp_hi);
    check("mtlo lo", lo, exp_lo);
    check("mtlo busy", {31'd0, busy}, 32'd0);
    check("mtlo done", {31'd0, done}, 32'd0);
    issue(3'd6, 32'h5555_5555, 32'd1);
    tick;
    check("rsvd busy", {31'd0, busy}, 32'd0);
    check("rsvd hi", hi, exp_hi);
    check("rsvd lo", lo, exp_lo);

    run("divu_poke", 3'd3, 32'hCAFE_F00D, 32'd1234, 10);
    tick;
    check("poke idle", {31'd0, busy}, 32'd0);

    // Reset in the middle of a mult aborts it with no done
    issue(3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (14) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort hi", hi, 32'd0);
    check("abort lo", lo, 32'd0);
    tick;
    check("abort no_done", {31'd0, done}, 32'd0);
    run("multu_3x5", 3'd1, 32'd3, 32'd5, 0);
    tick;

    // Back-to-back: second op issued in the done cycle of the first
    run("b2b_mul", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run("b2b_div", 3'd3, 32'd9, 32'd4, 0);
    tick;

    for (int i = 0; i < 12; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 2) == 0) rb = rb & 32'h0000_00FF;
      run("rand", rop, ra, rb, 0);
      if ($urandom_range(0, 1) == 0) tick;
    end
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
